// File: rtl/estacao_reserva_add_pkg.sv
// Shared definitions for the ADD/SUB reservation station:
// station tags, opcodes, empty-slot sentinels and FSM states.
package estacao_reserva_add_pkg;

    localparam logic [2:0] FREE_REGISTER     = 3'd0;
    localparam logic [2:0] RES_STATION_ADD1  = 3'd1;
    localparam logic [2:0] RES_STATION_ADD2  = 3'd2;
    localparam logic [2:0] RES_STATION_LOAD1 = 3'd3;
    localparam logic [2:0] RES_STATION_LOAD2 = 3'd4;

    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd3;
    localparam logic [2:0] LD  = 3'd4;
    localparam logic [2:0] ST  = 3'd5;

    localparam logic [15:0] Vj_Vk_sem_valor = 16'hFFF0;
    localparam logic [2:0]  Qj_Qk_sem_valor = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } estado_t;

    function automatic logic is_add_sub(input logic [2:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/estacao_reserva_add_ula_soma_sub.sv
// Combinational 16-bit adder/subtractor; SUB gives a-b, anything else a+b.
// Ports: opcode (3), a/b operands (16), y result (16, modulo 2^16).
module ula_soma_sub
    import estacao_reserva_add_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    always_comb begin
        y = (opcode == SUB) ? (a - b) : (a + b);
    end

endmodule

// File: rtl/estacao_reserva_add.sv
// ADD/SUB reservation station: captures operands/tags from dispatch,
// snoops the CDB, executes with fixed latency and requests the CDB.
// Ports: Clock/Reset, dispatch load (Enable_VQ, Opcode, Vj/Vk, Qj/Qk,
// R_target), CDB snoop (CDB_valid/tag/data), CDB_grant; outputs Busy,
// CDB_req, Res_tag, Res_data, Res_target.
module estacao_reserva_add
    import estacao_reserva_add_pkg::*;
#(
    parameter logic [2:0]  MY_TAG      = 3'd1,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable_VQ,
    input  logic [2:0]  Opcode,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    input  logic [2:0]  Qj,
    input  logic [2:0]  Qk,
    input  logic [3:0]  R_target,
    input  logic        CDB_valid,
    input  logic [2:0]  CDB_tag,
    input  logic [15:0] CDB_data,
    input  logic        CDB_grant,
    output logic        Busy,
    output logic        CDB_req,
    output logic [2:0]  Res_tag,
    output logic [15:0] Res_data,
    output logic [3:0]  Res_target
);

    localparam logic [3:0] CNT_INI = 4'(EXEC_CYCLES - 1);

    estado_t     state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] vj_q, vj_d;
    logic [15:0] vk_q, vk_d;
    logic [2:0]  qj_q, qj_d;
    logic [2:0]  qk_q, qk_d;
    logic [3:0]  rt_q, rt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic [15:0] alu_y;

    // A zero tag means "value present", so it can never match the CDB.
    function automatic logic cdb_hit(input logic [2:0] q);
        return CDB_valid && (q != Qj_Qk_sem_valor) && (CDB_tag == q);
    endfunction

    ula_soma_sub u_ula (
        .opcode (op_q),
        .a      (vj_q),
        .b      (vk_q),
        .y      (alu_y)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            vj_q    <= Vj_Vk_sem_valor;
            vk_q    <= Vj_Vk_sem_valor;
            qj_q    <= Qj_Qk_sem_valor;
            qk_q    <= Qj_Qk_sem_valor;
            rt_q    <= 4'd0;
            cnt_q   <= 4'd0;
            res_q   <= Vj_Vk_sem_valor;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            rt_q    <= rt_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        rt_d    = rt_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (Enable_VQ && is_add_sub(Opcode)) begin
                    op_d = Opcode;
                    vj_d = Vj;
                    vk_d = Vk;
                    qj_d = Qj;
                    qk_d = Qk;
                    rt_d = R_target;
                    // Same-cycle CDB bypass on the incoming tags.
                    if (cdb_hit(Qj)) begin
                        vj_d = CDB_data;
                        qj_d = Qj_Qk_sem_valor;
                    end
                    if (cdb_hit(Qk)) begin
                        vk_d = CDB_data;
                        qk_d = Qj_Qk_sem_valor;
                    end
                    if (qj_d == Qj_Qk_sem_valor &&
                        qk_d == Qj_Qk_sem_valor) begin
                        state_d = S_EXEC;
                        cnt_d   = CNT_INI;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cdb_hit(qj_q)) begin
                    vj_d = CDB_data;
                    qj_d = Qj_Qk_sem_valor;
                end
                if (cdb_hit(qk_q)) begin
                    vk_d = CDB_data;
                    qk_d = Qj_Qk_sem_valor;
                end
                if (qj_d == Qj_Qk_sem_valor &&
                    qk_d == Qj_Qk_sem_valor) begin
                    state_d = S_EXEC;
                    cnt_d   = CNT_INI;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_y;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                if (CDB_grant) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy       = (state_q != S_IDLE);
        CDB_req    = (state_q == S_WRITE);
        Res_tag    = CDB_req ? MY_TAG : FREE_REGISTER;
        Res_data   = res_q;
        Res_target = rt_q;
    end

endmodule

// File: doc/estacao_reserva_add.md
Name: estacao_reserva_add

Overview:
- Single ADD/SUB reservation station, directly downstream of the dispatch unit; two instances form ADD1 and ADD2.
- Captures operands or producer tags on the dispatcher's Enable_VQ pulse and snoops the common data bus (CDB) for pending operands.
- Executes through a fixed-latency adder/subtractor, then requests the CDB to broadcast the result tagged with its own station number.
- Drives Busy back to the dispatch unit, which uses it for station allocation.

Parameters:
- MY_TAG, 3'd1: this station's tag on the CDB (1 = ADD1, 2 = ADD2).
- EXEC_CYCLES, 2: execute latency in cycles, legal range 1..15.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable_VQ  in  1  one-cycle load pulse from the dispatch unit.
- Opcode  in  3  instruction opcode: 3'd2 = ADD, 3'd3 = SUB.
- Vj, Vk  in  16  operand values; valid when the matching Q is 0.
- Qj, Qk  in  3  producer tags; 0 = value present, 1..4 = ADD1/ADD2/LOAD1/LOAD2.
- R_target  in  4  destination register, carried through to the result.
- CDB_valid  in  1  CDB carries a result this cycle.
- CDB_tag  in  3  producing station of the CDB result.
- CDB_data  in  16  CDB result value.
- CDB_grant  in  1  arbiter grant for this station's request.
- Busy  out  1  station occupied.
- CDB_req  out  1  result ready; requests the CDB.
- Res_tag  out  3  equals MY_TAG while CDB_req=1, otherwise 0.
- Res_data  out  16  result value.
- Res_target  out  4  destination register of the result.

Behaviour:
- Reset values, and the required outcome of any reset mid-operation:
  - state IDLE, Busy=0, CDB_req=0, Res_tag=0.
  - Res_data=16'hFFF0, Res_target=0.
  - stored Vj/Vk=16'hFFF0, stored Qj/Qk=0.
  - any in-flight operation is discarded and never broadcast.
- State machine:
  - IDLE -> WAIT on Enable_VQ with Opcode ADD or SUB.
  - WAIT -> EXEC when both stored Q are 0.
  - EXEC -> WRITE when the latency counter expires.
  - WRITE -> IDLE when CDB_grant is sampled high.
- Capture (IDLE, Enable_VQ=1, cycle N):
  - latch Opcode, Vj, Vk, Qj, Qk and R_target.
  - Busy=1 from N+1.
  - If both incoming Q are 0, go straight to EXEC at N+1 instead of WAIT.
- Capture bypass: if CDB_valid=1 in cycle N and CDB_tag equals a nonzero incoming Qj/Qk, store CDB_data as that operand and clear its Q. This is evaluated before the direct-to-EXEC decision.
- Illegal capture:
  - Enable_VQ with any other opcode is ignored; the station stays IDLE.
  - Enable_VQ while Busy=1 is ignored; the stored contents are unchanged.
- Snoop (WAIT and capture cycle):
  - for each operand with stored Q != 0, when CDB_valid=1 and CDB_tag matches, load CDB_data and clear Q.
  - both operands may resolve in the same cycle.
  - CDB_tag=0 never matches.
  - WAIT -> EXEC occurs on the cycle after the last Q reaches 0.
- EXEC:
  - counter is loaded with EXEC_CYCLES-1 on entry and decrements each cycle.
  - at 0 the station moves to WRITE, so EXEC lasts exactly EXEC_CYCLES cycles.
  - the result is registered into Res_data on the last EXEC cycle.
- Arithmetic: ADD gives Vj+Vk and SUB gives Vj-Vk, both modulo 2^16. Carry and borrow are discarded.
- WRITE:
  - CDB_req=1, Res_tag=MY_TAG, Res_target = stored R_target.
  - Res_data is held stable until grant.
  - on the cycle after grant: CDB_req=0, Res_tag=0, Busy=0, state IDLE.
  - a new Enable_VQ is accepted from that IDLE cycle onward.
- Grant without request: CDB_grant=1 outside WRITE has no effect.
- Stale CDB: CDB traffic in EXEC or WRITE is ignored.
- Latency: with both operands ready at capture in cycle N, CDB_req rises at N+1+EXEC_CYCLES, i.e. N+3 at the default setting.

Decomposition:
- Shared package:
  - station tags: FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2, RES_STATION_LOAD1=3, RES_STATION_LOAD2=4.
  - opcodes ADD=3'd2, SUB=3'd3, LD=3'd4, ST=3'd5.
  - sentinels Vj_Vk_sem_valor=16'hFFF0, Qj_Qk_sem_valor=3'b000.
  - FSM state encoding.
- Sub-module: ula_soma_sub, a combinational 16-bit add/sub selected by opcode. The FSM, counter and snoop logic stay in the top module.

Test Plan:
- Ready capture: Enable_VQ with ADD, Vj=5, Vk=7, Qj=Qk=0, R_target=3, MY_TAG=1 at cycle N -> Busy=1 at N+1; CDB_req=1, Res_data=12, Res_tag=1, Res_target=3 at N+3; grant at N+4 -> Busy=0 at N+5.
- SUB wrap: Vj=3, Vk=5 -> Res_data=16'hFFFE.
- Pending operand:
  - capture ADD with Qj=3 (LOAD1), Vk=10.
  - station stays in WAIT; CDB traffic with tag 4 is ignored.
  - CDB_valid with tag 3, data 20 at cycle M -> CDB_req at M+1+EXEC_CYCLES with Res_data=30.
- Dual and bypass: Qj=3, Qk=4 resolved by one CDB per cycle in consecutive cycles -> correct sum. Capture in the same cycle as a CDB broadcast of tag Qj -> value taken, no WAIT stall.
- Back-pressure and ignore:
  - CDB_grant held low for 5 cycles -> CDB_req and Res_data stable throughout.
  - Enable_VQ while Busy -> no state change.
  - Enable_VQ with Opcode=LD -> station stays IDLE.
- Reset mid-EXEC: Reset pulse -> all outputs at reset values next cycle; no CDB_req ever asserted for the discarded operation.
